// File: rtl/mult_div_unit_if.sv
// Core-side bus of the HI/LO multiply/divide unit: operation request, MTHI/MTLO
// moves, status pulses and the architectural HI/LO registers.
interface mult_div_unit_if;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_rs;
    logic [31:0] i_rt;
    logic        i_mthi;
    logic        i_mtlo;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_div_zero;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    modport master (
        output i_start, i_op, i_rs, i_rt, i_mthi, i_mtlo, i_wdata,
        input  o_busy, o_done, o_div_zero, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_rs, i_rt, i_mthi, i_mtlo, i_wdata,
        output o_busy, o_done, o_div_zero, o_hi, o_lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO (IDLE->ITER x32->FIX->WB).
// Optional MDU_FAST_MULT_EN: single-cycle 64-bit multiply going IDLE->WB directly.
module mult_div_unit (
    input  logic           i_clk,
    input  logic           i_rst,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2, WB = 2'd3} state_t;

    state_t      state, next_state;
    logic [1:0]  op_q;
    logic [31:0] opnd_q;
    logic [63:0] acc, acc_step;
    logic [5:0]  cnt;
    logic        neg_lo, neg_hi, zero_div_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q, div_zero_out;
    logic [32:0] mul_sum, div_diff;

    logic        in_signed, in_div, in_zero_div, in_fast;
    logic [31:0] a_mag, b_mag;

    assign in_signed   = ~bus.i_op[0];
    assign in_div      = bus.i_op[1];
    assign a_mag       = (in_signed && bus.i_rs[31]) ? (~bus.i_rs + 32'd1) : bus.i_rs;
    assign b_mag       = (in_signed && bus.i_rt[31]) ? (~bus.i_rt + 32'd1) : bus.i_rt;
    assign in_zero_div = in_div && (bus.i_rt == '0);

`ifdef MDU_FAST_MULT_EN
    logic [63:0] fast_prod;
    // Low 64 bits of the sign-extended product are the correct signed result.
    assign fast_prod = in_signed ? ({{32{bus.i_rs[31]}}, bus.i_rs} * {{32{bus.i_rt[31]}}, bus.i_rt})
                                 : ({32'd0, bus.i_rs} * {32'd0, bus.i_rt});
    assign in_fast   = ~in_div;
`else
    assign in_fast   = 1'b0;
`endif

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_q} : 33'd0);
        div_diff = acc[63:31] - {1'b0, opnd_q};
        if (op_q[1])
            acc_step = div_diff[32] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
        else
            acc_step = {mul_sum, acc[31:1]};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.i_start) next_state = (in_zero_div || in_fast) ? WB : ITER;
            ITER: if (cnt == 6'd31) next_state = FIX;
            FIX:  next_state = WB;
            WB:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q         <= '0;
            opnd_q       <= '0;
            acc          <= '0;
            cnt          <= '0;
            neg_lo       <= 1'b0;
            neg_hi       <= 1'b0;
            zero_div_q   <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            done_q       <= 1'b0;
            div_zero_out <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            div_zero_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        op_q       <= bus.i_op;
                        cnt        <= '0;
                        zero_div_q <= in_zero_div;
                        neg_lo     <= in_signed && (bus.i_rs[31] ^ bus.i_rt[31]);
                        neg_hi     <= in_signed && in_div && bus.i_rs[31];
                        if (in_div) begin
                            opnd_q <= b_mag;
                            acc    <= {32'd0, a_mag};
                        end else begin
                            opnd_q <= a_mag;
                            acc    <= {32'd0, b_mag};
                        end
`ifdef MDU_FAST_MULT_EN
                        if (in_fast) acc <= fast_prod;
`endif
                    end else begin
                        if (bus.i_mthi) hi_q <= bus.i_wdata;
                        if (bus.i_mtlo) lo_q <= bus.i_wdata;
                    end
                end
                ITER: begin
                    acc <= acc_step;
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    if (op_q[1]) begin
                        if (neg_hi) acc[63:32] <= ~acc[63:32] + 32'd1;
                        if (neg_lo) acc[31:0]  <= ~acc[31:0] + 32'd1;
                    end else if (neg_lo) begin
                        acc <= ~acc + 64'd1;
                    end
                end
                WB: begin
                    if (!zero_div_q) begin
                        hi_q <= acc[63:32];
                        lo_q <= acc[31:0];
                    end
                    done_q       <= 1'b1;
                    div_zero_out <= zero_div_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy     = (state != IDLE);
    assign bus.o_done     = done_q;
    assign bus.o_div_zero = div_zero_out;
    assign bus.o_hi       = hi_q;
    assign bus.o_lo       = lo_q;
endmodule
